data_rd_seq: RTL

- Sequencer that drives the read port of the data block RAM for one 2-D tile.
- Fetches i_row_num rows of i_row_len words; rows start i_row_stride words apart from i_base_addr.
- Generates per-cycle address/read-enable under stall backpressure.
- Tracks BRAM read latency to flag returned data, the last word, and completion to the downstream PE feeder.

---
 rtl/data_rd_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/data_rd_seq.sv
// Read-port sequencer for the data block RAM. It walks one 2-D tile row by row
// and tracks BRAM read latency to mark returned data, the last word and completion.
module data_rd_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [CNT_WIDTH-1:0]  i_row_len,
  input  logic [CNT_WIDTH-1:0]  i_row_num,
  input  logic [CNT_WIDTH-1:0]  i_row_stride,
  input  logic                  i_stall,
  output logic                  o_rden,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_data_vld,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [CNT_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  col_q, col_d;
  logic [CNT_WIDTH-1:0]  row_q, row_d;
  logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0] last_pipe_q, last_pipe_d;
  logic [RD_LATENCY-1:0] vld_shift, last_shift;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  rden, last_issue, done;
  logic                  col_end, row_end;

  // Counters compare against len-1/num-1 so a full-width len/num never overflows.
  assign col_end = (col_q == len_q - CNT_WIDTH'(1));
  assign row_end = (row_q == num_q - CNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    row_base_d  = row_base_q;
    len_d       = len_q;
    num_d       = num_q;
    stride_d    = stride_q;
    col_d       = col_q;
    row_d       = row_q;
    err_d       = 1'b0;
    rden        = 1'b0;
    last_issue  = 1'b0;
    done        = 1'b0;
    vld_shift   = vld_pipe_q << 1;
    last_shift  = last_pipe_q << 1;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_row_len == '0 || i_row_num == '0) begin
            err_d = 1'b1;
          end else begin
            len_d      = i_row_len;
            num_d      = i_row_num;
            stride_d   = i_row_stride;
            row_base_d = i_base_addr;
            col_d      = '0;
            row_d      = '0;
            state_d    = RUN;
          end
        end
      end
      RUN: begin
        rden = ~i_stall;
        if (rden) begin
          if (col_end) begin
            col_d      = '0;
            row_base_d = row_base_q + ADDR_WIDTH'(stride_q);
            row_d      = row_q + CNT_WIDTH'(1);
            if (row_end) begin
              last_issue = 1'b1;
              state_d    = DRAIN;
            end
          end else begin
            col_d = col_q + CNT_WIDTH'(1);
          end
        end
      end
      // Leave once the shifted pipe is empty, so DONE follows the final valid directly.
      DRAIN: begin
        if (~|vld_shift) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    vld_pipe_d  = vld_shift | RD_LATENCY'(rden);
    last_pipe_d = last_shift | RD_LATENCY'(last_issue);

    if (i_abort && state_q != IDLE) begin
      state_d     = IDLE;
      rden        = 1'b0;
      done        = 1'b0;
      vld_pipe_d  = '0;
      last_pipe_d = '0;
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_base_q  <= '0;
      len_q       <= '0;
      num_q       <= '0;
      stride_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_base_q  <= row_base_d;
      len_q       <= len_d;
      num_q       <= num_d;
      stride_q    <= stride_d;
      col_q       <= col_d;
      row_q       <= row_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_rden     = rden;
  assign o_addr     = (state_q == RUN) ? row_base_q + ADDR_WIDTH'(col_q) : '0;
  assign o_data_vld = vld_pipe_q[RD_LATENCY-1];
  assign o_last     = last_pipe_q[RD_LATENCY-1];
  assign o_busy     = busy_q;
  assign o_done     = done;
  assign o_err      = err_q;

endmodule
